phys_regread_stage: RTL

Parametrised register-read stage between the issue queues (IQ/LSQ) and the execute/memory units of the out-of-order core. It owns the physical register file, accepts one issued op per cycle over a valid/ready handshake, and reads two source operands plus store data. Operands are forwarded from up to `WB_PORTS` same-cycle writebacks. The op is presented to execute from a single output register with its own valid/ready handshake, stall (`FREEZE`) and flush.

---
 rtl/phys_regread_stage_if.sv | 50 +++++
 rtl/phys_regread_stage.sv | 124 ++++++++++++
 2 files changed

// File: rtl/phys_regread_stage_if.sv
// phys_regread_stage_if: buses around the register-read stage.
//   iss_*  issued op from IQ/LSQ, valid/ready handshake (stage is the receiver)
//   out_*  op towards execute/memory, valid/ready handshake (stage is the sender)
//   wb_*   writeback ports; port k at [k*PREG_IDX +: PREG_IDX] / [k*DATA_W +: DATA_W]
// Modports: master = issue/execute/writeback side, slave = the stage itself.
interface phys_regread_stage_if #(
    parameter int unsigned PREG_IDX  = 6,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ROB_IDX   = 6,
    parameter int unsigned WB_PORTS  = 2,
    parameter int unsigned PAYLOAD_W = 137
);
    logic                         iss_valid;
    logic                         iss_ready;
    logic                         iss_is_mem;
    logic [PREG_IDX-1:0]          iss_srcA;
    logic [PREG_IDX-1:0]          iss_srcB;
    logic [PREG_IDX-1:0]          iss_dest;
    logic [ROB_IDX-1:0]           iss_rob;
    logic [PAYLOAD_W-1:0]         iss_payload;

    logic                         out_valid;
    logic                         out_ready;
    logic                         out_is_mem;
    logic [ROB_IDX-1:0]           out_rob;
    logic [PAYLOAD_W-1:0]         out_payload;
    logic [DATA_W-1:0]            out_opA;
    logic [DATA_W-1:0]            out_opB;
    logic [DATA_W-1:0]            out_stdata;

    logic [WB_PORTS-1:0]          wb_valid;
    logic [WB_PORTS*PREG_IDX-1:0] wb_index;
    logic [WB_PORTS*DATA_W-1:0]   wb_data;

    modport master (
        output iss_valid, iss_is_mem, iss_srcA, iss_srcB, iss_dest, iss_rob, iss_payload,
        input  iss_ready,
        input  out_valid, out_is_mem, out_rob, out_payload, out_opA, out_opB, out_stdata,
        output out_ready,
        output wb_valid, wb_index, wb_data
    );

    modport slave (
        input  iss_valid, iss_is_mem, iss_srcA, iss_srcB, iss_dest, iss_rob, iss_payload,
        output iss_ready,
        output out_valid, out_is_mem, out_rob, out_payload, out_opA, out_opB, out_stdata,
        input  out_ready,
        input  wb_valid, wb_index, wb_data
    );
endinterface

// File: rtl/phys_regread_stage.sv
// phys_regread_stage: register-read stage between the issue queues and execute.
// Owns the physical register file, reads srcA/srcB/dest for the issued op with same-cycle
// writeback bypass, and presents the op from a single output register.
// Ports:
//   CLK     clock, rising edge
//   RESET   asynchronous active-low reset (clears register file and output register)
//   FREEZE  global stall: no accept, output register holds, writebacks still land
//   FLUSH   squash the held op at the next edge (wins over FREEZE)
//   bus     phys_regread_stage_if.slave: issue, output and writeback buses
module phys_regread_stage #(
    parameter int unsigned PREG_COUNT  = 64,
    parameter int unsigned PREG_IDX    = 6,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ROB_IDX     = 6,
    parameter int unsigned WB_PORTS    = 2,
    parameter int unsigned PAYLOAD_W   = 137,
    parameter bit          ZERO_REG_EN = 1'b1
) (
    input logic                 CLK,
    input logic                 RESET,
    input logic                 FREEZE,
    input logic                 FLUSH,
    phys_regread_stage_if.slave bus
);

    logic [DATA_W-1:0]   regs [PREG_COUNT];

    logic [PREG_IDX-1:0] wb_idx [WB_PORTS];
    logic [DATA_W-1:0]   wb_dat [WB_PORTS];
    logic                wb_hit [WB_PORTS];  // port writes an index that actually exists
    logic [PREG_IDX-1:0] rd_idx [3];
    logic [DATA_W-1:0]   rd_val [3];         // resolved srcA, srcB, dest

    logic                accept;
    logic                out_valid_q;
    logic                out_is_mem_q;
    logic [ROB_IDX-1:0]  out_rob_q;
    logic [PAYLOAD_W-1:0] out_payload_q;
    logic [DATA_W-1:0]   out_opA_q;
    logic [DATA_W-1:0]   out_opB_q;
    logic [DATA_W-1:0]   out_stdata_q;

    always_comb begin
        for (int unsigned k = 0; k < WB_PORTS; k++) begin
            wb_idx[k] = bus.wb_index[k*PREG_IDX +: PREG_IDX];
            wb_dat[k] = bus.wb_data[k*DATA_W +: DATA_W];
            wb_hit[k] = bus.wb_valid[k] && (32'(wb_idx[k]) < PREG_COUNT) &&
                        !(ZERO_REG_EN && (wb_idx[k] == '0));
        end
    end

    // Later ports override earlier ones, so the highest-numbered matching port wins.
    always_comb begin
        rd_idx[0] = bus.iss_srcA;
        rd_idx[1] = bus.iss_srcB;
        rd_idx[2] = bus.iss_dest;
        for (int unsigned r = 0; r < 3; r++) begin
            rd_val[r] = '0;
            if (32'(rd_idx[r]) < PREG_COUNT) begin
                rd_val[r] = regs[rd_idx[r]];
                for (int unsigned k = 0; k < WB_PORTS; k++) begin
                    if (wb_hit[k] && (wb_idx[k] == rd_idx[r])) begin
                        rd_val[r] = wb_dat[k];
                    end
                end
            end
            if (ZERO_REG_EN && (rd_idx[r] == '0)) begin
                rd_val[r] = '0;
            end
        end
    end

    // Non-blocking writes in port order: the last (highest) port to the same index wins.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int unsigned i = 0; i < PREG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < WB_PORTS; k++) begin
                if (wb_hit[k]) begin
                    regs[wb_idx[k]] <= wb_dat[k];
                end
            end
        end
    end

    assign bus.iss_ready = !FREEZE && !FLUSH && (!out_valid_q || bus.out_ready);
    assign accept        = bus.iss_valid && bus.iss_ready;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            out_valid_q   <= 1'b0;
            out_is_mem_q  <= 1'b0;
            out_rob_q     <= '0;
            out_payload_q <= '0;
            out_opA_q     <= '0;
            out_opB_q     <= '0;
            out_stdata_q  <= '0;
        end else if (FLUSH) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q   <= 1'b1;
            out_is_mem_q  <= bus.iss_is_mem;
            out_rob_q     <= bus.iss_rob;
            out_payload_q <= bus.iss_payload;
            out_opA_q     <= rd_val[0];
            // Mem ops carry store data instead of a second ALU operand.
            out_opB_q     <= bus.iss_is_mem ? '0 : rd_val[1];
            out_stdata_q  <= bus.iss_is_mem ? rd_val[2] : '0;
        end else if (out_valid_q && bus.out_ready && !FREEZE) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_is_mem  = out_is_mem_q;
    assign bus.out_rob     = out_rob_q;
    assign bus.out_payload = out_payload_q;
    assign bus.out_opA     = out_opA_q;
    assign bus.out_opB     = out_opB_q;
    assign bus.out_stdata  = out_stdata_q;

endmodule
